fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter_if.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 135 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side / FIFO-write-side bundle of the round-robin write arbiter.
// The master side is the environment (producers plus FIFO full flag); the
// slave side is the arbiter itself.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       ack;
  logic                   fifo_full;
  logic                   fifo_write_en;
  logic [WIDTH-1:0]       fifo_d_in;
  logic                   grant_valid;
  logic [2:0]             grant_id;

  modport master (
    output req, req_data, fifo_full,
    input  ack, fifo_write_en, fifo_d_in, grant_valid, grant_id
  );

  modport slave (
    input  req, req_data, fifo_full,
    output ack, fifo_write_en, fifo_d_in, grant_valid, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N_REQ producers share one FIFO write port.
// One owner at a time, bursts bounded by MAX_BURST accepted words, FIFO full
// stalls the owner without costing it burst credit. On release the pointer
// moves past the old owner and re-arbitration happens in the same cycle, so
// back-to-back grants have no bubble.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 16,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_r, state_s;
  logic [2:0] owner_r, owner_s;
  logic [2:0] rr_ptr_r, rr_ptr_s;
  logic [3:0] burst_cnt_r, burst_cnt_s;
  logic [3:0] win_s;          // {found, index}
  logic [2:0] rel_ptr_s;
  logic [7:0] req8_s;
  logic       owner_req_s;
  logic       accept_s;
  logic       release_s;
  logic [WIDTH-1:0] owner_data_s;

  // First requester at or after ptr, scanning upward modulo N_REQ.
  // Returns {found, index}.
  function automatic logic [3:0] pick_winner(input logic [7:0] req,
                                             input logic [2:0] ptr);
    logic [3:0] res;
    logic [3:0] sum;
    res = 4'b0000;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + 4'(k);
      sum = (sum >= 4'(N_REQ)) ? sum - 4'(N_REQ) : sum;
      res = req[sum[2:0]] ? {1'b1, sum[2:0]} : res;
    end
    return res;
  endfunction

  // Zero-extend requests so the owner index always addresses a valid bit.
  always_comb begin
    req8_s      = 8'(bus.req);
    owner_req_s = req8_s[owner_r];
    rel_ptr_s   = (owner_r == 3'(N_REQ - 1)) ? 3'd0 : owner_r + 3'd1;
  end

  // Select the current owner's data word from the flattened request bus.
  always_comb begin
    owner_data_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      owner_data_s = (owner_r == 3'(i)) ? bus.req_data[i*WIDTH +: WIDTH] : owner_data_s;
    end
  end

  // Next-state logic: grant, accept, burst counting, release and re-arbitration.
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    rr_ptr_s    = rr_ptr_r;
    burst_cnt_s = burst_cnt_r;
    accept_s    = 1'b0;
    release_s   = 1'b0;
    win_s       = 4'b0000;
    case (state_r)
      IDLE: begin
        win_s = pick_winner(req8_s, rr_ptr_r);
        if (win_s[3]) begin
          state_s     = GRANT;
          owner_s     = win_s[2:0];
          burst_cnt_s = 4'd0;
        end else begin
          state_s     = IDLE;
        end
      end
      GRANT: begin
        accept_s    = owner_req_s & ~bus.fifo_full;
        release_s   = ~owner_req_s |
                      (accept_s & (burst_cnt_r == 4'(MAX_BURST - 1)));
        burst_cnt_s = accept_s ? burst_cnt_r + 4'd1 : burst_cnt_r;
        if (release_s) begin
          // Old owner now has lowest priority; re-arbitrate immediately.
          rr_ptr_s    = rel_ptr_s;
          win_s       = pick_winner(req8_s, rel_ptr_s);
          burst_cnt_s = 4'd0;
          state_s     = win_s[3] ? GRANT : IDLE;
          owner_s     = win_s[3] ? win_s[2:0] : owner_r;
        end else begin
          state_s     = GRANT;
        end
      end
      default: begin
        state_s     = IDLE;
        owner_s     = 3'd0;
        rr_ptr_s    = 3'd0;
        burst_cnt_s = 4'd0;
      end
    endcase
  end

  // Output decode; reset suppresses any write in the cycle it is asserted.
  always_comb begin
    bus.grant_valid   = (state_r == GRANT);
    bus.grant_id      = (state_r == GRANT) ? owner_r : 3'd0;
    bus.fifo_d_in     = (state_r == GRANT) ? owner_data_s : '0;
    bus.fifo_write_en = accept_s & ~rst;
    bus.ack           = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.ack[i] = accept_s & ~rst & (owner_r == 3'(i));
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      owner_r     <= 3'd0;
      rr_ptr_r    <= 3'd0;
      burst_cnt_r <= 4'd0;
    end else begin
      state_r     <= state_s;
      owner_r     <= owner_s;
      rr_ptr_r    <= rr_ptr_s;
      burst_cnt_r <= burst_cnt_s;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a reference model predicts each cycle's outputs
// and each written word; a monitor pops and compares on the falling edge.
module tb_fifo_wr_arbiter;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.WIDTH(W), .N_REQ(N)) bus ();

  fifo_wr_arbiter #(.WIDTH(W), .N_REQ(N), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic         gv;
    logic [2:0]   gid;
    logic [N-1:0] ack;
    logic         wen;
    logic [W-1:0] din;
  } status_t;

  typedef struct {
    int           id;
    logic [W-1:0] data;
  } wr_t;

  status_t st_q[$];
  wr_t     wr_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: owner (-1 = none), rotating pointer, words in this grant.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  function automatic int rr_pick(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, predict outputs, advance the model.
  task automatic step(input logic r, input logic [N-1:0] rq,
                      input logic [N*W-1:0] d, input logic full,
                      output logic [N-1:0] ack_o);
    status_t s;
    wr_t     w;
    logic    acc;
    @(posedge clk);
    #1;
    rst = r; bus.req = rq; bus.req_data = d; bus.fifo_full = full;
    s.gv  = (m_owner >= 0);
    s.gid = s.gv ? 3'(m_owner) : 3'd0;
    s.ack = '0;
    s.wen = 1'b0;
    s.din = s.gv ? d[m_owner*W +: W] : '0;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      m_owner = rr_pick(rq, m_ptr);
      m_cnt = 0;
    end else begin
      acc = rq[m_owner] && !full;
      if (acc) begin
        s.ack[m_owner] = 1'b1;
        s.wen = 1'b1;
        m_cnt++;
        w.id = m_owner; w.data = s.din;
        wr_q.push_back(w);
      end
      if (!rq[m_owner] || (acc && m_cnt == MB)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = rr_pick(rq, m_ptr);
        m_cnt   = 0;
      end
    end
    st_q.push_back(s);
    ack_o = s.ack;
  endtask

  // Monitor: compare the predicted status every cycle, and each FIFO write.
  status_t ms;
  wr_t     mw;
  always @(negedge clk) begin
    if (st_q.size() > 0) begin
      ms = st_q.pop_front();
      check("grant_valid", 32'(bus.grant_valid), 32'(ms.gv));
      check("grant_id", 32'(bus.grant_id), 32'(ms.gid));
      check("ack", 32'(bus.ack), 32'(ms.ack));
      check("write_en", 32'(bus.fifo_write_en), 32'(ms.wen));
      check("ack_onehot0", 32'($onehot0(bus.ack)), 32'd1);
      if (ms.gv) check("d_in", 32'(bus.fifo_d_in), 32'(ms.din));
      else       check("d_in_idle", 32'(bus.fifo_d_in), 32'd0);
      if (bus.fifo_write_en === 1'b1) begin
        if (wr_q.size() == 0) begin
          check("write_unexpected", 32'd1, 32'd0);
        end else begin
          mw = wr_q.pop_front();
          check("write_data", 32'(bus.fifo_d_in), 32'(mw.data));
          check("write_owner_ack", 32'(bus.ack), 32'(1 << mw.id));
        end
      end
    end
  end

  logic [N-1:0]   rq;
  logic [N-1:0]   last_ack;
  logic [N*W-1:0] dd;
  int rem [N];
  int fcnt;

  initial begin
    rst = 1'b1; bus.req = '0; bus.req_data = '0; bus.fifo_full = 1'b0;
    rq = '0; dd = '0; last_ack = '0;
    repeat (2) @(posedge clk);
    step(1'b1, '0, '0, 1'b0, last_ack);

    // Single requester held: burst of 4, re-granted without bubble.
    dd = '0; dd[0 +: W] = 16'h00AA;
    for (int c = 0; c < 8; c++) step(1'b0, 4'b0001, dd, 1'b0, last_ack);

    // Two steady requesters alternate in bursts.
    step(1'b1, '0, '0, 1'b0, last_ack);
    dd[2*W +: W] = 16'h0C0C;
    for (int c = 0; c < 20; c++) step(1'b0, 4'b0101, dd, 1'b0, last_ack);

    // Full stall mid-burst for owner 1.
    step(1'b1, '0, '0, 1'b0, last_ack);
    dd[1*W +: W] = 16'h1111;
    for (int c = 0; c < 3; c++) step(1'b0, 4'b0010, dd, 1'b0, last_ack);
    for (int c = 0; c < 3; c++) step(1'b0, 4'b0010, dd, 1'b1, last_ack);
    for (int c = 0; c < 4; c++) step(1'b0, 4'b0010, dd, 1'b0, last_ack);

    // Owner 3 drops after one word; grant wraps to 0.
    step(1'b1, '0, '0, 1'b0, last_ack);
    dd[3*W +: W] = 16'h3333;
    step(1'b0, 4'b1000, dd, 1'b0, last_ack);
    step(1'b0, 4'b1001, dd, 1'b0, last_ack);
    for (int c = 0; c < 3; c++) step(1'b0, 4'b0001, dd, 1'b0, last_ack);

    // Reset mid-burst for owner 2, then arbitration from pointer 0.
    step(1'b1, '0, '0, 1'b0, last_ack);
    for (int c = 0; c < 3; c++) step(1'b0, 4'b0100, dd, 1'b0, last_ack);
    step(1'b1, 4'b0100, dd, 1'b0, last_ack);
    for (int c = 0; c < 4; c++) step(1'b0, 4'b0110, dd, 1'b0, last_ack);

    // End-to-end with a depth-8 FIFO: two tagged words per requester.
    step(1'b1, '0, '0, 1'b0, last_ack);
    fcnt = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 2;
      dd[i*W +: W] = 16'h00A0 | 16'(i);
    end
    for (int c = 0; c < 24; c++) begin
      if (c == 18) rem[0] = 1;        // one more word while full
      if (c == 21) fcnt = fcnt - 1;   // a read frees a slot
      for (int i = 0; i < N; i++) rq[i] = (rem[i] > 0);
      step(1'b0, rq, dd, (fcnt >= 8), last_ack);
      for (int i = 0; i < N; i++) begin
        if (last_ack[i]) begin rem[i]--; fcnt++; end
      end
    end

    // Randomised traffic with holds, drops, stalls and occasional reset.
    step(1'b1, '0, '0, 1'b0, last_ack);
    rq = '0; last_ack = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rq[i] && !last_ack[i] && $urandom_range(0, 99) < 90) begin
          rq[i] = 1'b1;
        end else begin
          rq[i] = ($urandom_range(0, 99) < 55);
          dd[i*W +: W] = 16'($urandom);
        end
      end
      step(($urandom_range(0, 199) == 0), rq, dd,
           ($urandom_range(0, 99) < 20), last_ack);
    end

    step(1'b0, '0, dd, 1'b0, last_ack);
    step(1'b0, '0, dd, 1'b0, last_ack);
    repeat (2) @(negedge clk);
    check("wr_q_leftover", 32'(wr_q.size()), 32'd0);
    check("st_q_leftover", 32'(st_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
